// File: rtl/pkg_opengpu.sv
// Shared GPU memory-system types and geometry constants.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pkg_opengpu;

  localparam int ADDR_WIDTH       = 32;
  localparam int CACHE_LINE_BYTES = 64;
  localparam int CACHE_LINE_BITS  = CACHE_LINE_BYTES * 8;

  // Free-running fill counters; both wrap silently at 2^32.
  typedef struct packed {
    logic [31:0] fills;
    logic [31:0] stall_cycles;
  } fill_resp_stats_t;

endpackage

// File: rtl/l2_line_fill_responder.sv
// Fetches one cache line as BEATS word reads from backing memory and returns it whole.
// Latency: resp_valid 18 cycles after accept with an always-ready, 1-cycle memory.
// Backpressure: one fill at a time (ready only in IDLE); mem_req_ready stalls issue; no resp backpressure.
module l2_line_fill_responder #(
  parameter int ADDR_WIDTH = pkg_opengpu::ADDR_WIDTH,
  parameter int LINE_BYTES = pkg_opengpu::CACHE_LINE_BYTES,
  parameter int WORD_BYTES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  output logic                            ready,
  output logic                            resp_valid,
  output logic [LINE_BYTES*8-1:0]         resp_rdata,
  output logic                            mem_req_valid,
  output logic [ADDR_WIDTH-1:0]           mem_req_addr,
  input  logic                            mem_req_ready,
  input  logic                            mem_resp_valid,
  input  logic [WORD_BYTES*8-1:0]         mem_resp_data,
  output logic                            err_spurious,
  output pkg_opengpu::fill_resp_stats_t   stats
);

  localparam int BEATS     = LINE_BYTES / WORD_BYTES;
  localparam int WORD_BITS = WORD_BYTES * 8;
  localparam int LINE_BITS = LINE_BYTES * 8;
  localparam int CNT_W     = $clog2(BEATS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RESPOND
  } state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              issued_q, issued_d;
  logic [CNT_W-1:0]              received_q, received_d;
  logic [ADDR_WIDTH-1:0]         base_q, base_d;
  logic [LINE_BITS-1:0]          line_q, line_d;
  logic                          err_q, err_d;
  pkg_opengpu::fill_resp_stats_t stats_q, stats_d;

  // Beat address walks the line in word steps from the aligned base.
  assign mem_req_addr = base_q + (ADDR_WIDTH'(issued_q) * ADDR_WIDTH'(WORD_BYTES));
  assign resp_rdata   = line_q;
  assign err_spurious = err_q;
  assign stats        = stats_q;

  // Next-state, beat bookkeeping and handshake outputs; issue and receive are independent so they may coincide.
  always_comb begin
    state_d       = state_q;
    issued_d      = issued_q;
    received_d    = received_q;
    base_d        = base_q;
    line_d        = line_q;
    err_d         = err_q;
    stats_d       = stats_q;
    ready         = 1'b0;
    resp_valid    = 1'b0;
    mem_req_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (mem_resp_valid) err_d = 1'b1;
        if (req_valid) begin
          state_d    = ST_FETCH;
          base_d     = req_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
          issued_d   = '0;
          received_d = '0;
        end
      end

      ST_FETCH: begin
        mem_req_valid = (issued_q < CNT_W'(BEATS));
        if (mem_req_valid) begin
          if (mem_req_ready) issued_d = issued_q + 1'b1;
          else stats_d.stall_cycles = stats_q.stall_cycles + 32'd1;
        end
        if (mem_resp_valid) begin
          if (received_q < CNT_W'(BEATS)) begin
            line_d[int'(received_q) * WORD_BITS +: WORD_BITS] = mem_resp_data;
            received_d = received_q + 1'b1;
            if (received_q == CNT_W'(BEATS - 1)) state_d = ST_RESPOND;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_RESPOND: begin
        resp_valid    = 1'b1;
        stats_d.fills = stats_q.fills + 32'd1;
        state_d       = ST_IDLE;
        if (mem_resp_valid) err_d = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset; reset abandons any fill in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      issued_q   <= '0;
      received_q <= '0;
      base_q     <= '0;
      line_q     <= '0;
      err_q      <= 1'b0;
      stats_q    <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      base_q     <= base_d;
      line_q     <= line_d;
      err_q      <= err_d;
      stats_q    <= stats_d;
    end
  end

endmodule
